// File: rtl/link_token_rx.sv
// Receive end of the distributed-sim link: buffers tokens addressed to this node and
// releases them in order once the local cycle counter reaches each token's stamp.
module link_token_rx #(
  parameter int unsigned ID    = 0,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_wen_from_link,
  input  logic [31:0]            i_token_from_link,
  input  logic [31:0]            i_clk_cnt_from_link,
  input  logic [31:0]            i_id_from_link,
  output logic                   o_valid,
  output logic [31:0]            o_token,
  output logic [31:0]            o_clk_cnt,
  input  logic                   i_ready,
  output logic [31:0]            o_local_cnt,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

  localparam logic [1:0] S_EMPTY   = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;

  logic [31:0]   tok_mem   [DEPTH];
  logic [31:0]   stamp_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_next;
  logic [AW:0]   level;
  logic [1:0]    state;
  logic [1:0]    state_nxt;

  logic          id_match;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          load;
  logic          cand_avail;
  logic [31:0]   cand_tok;
  logic [31:0]   cand_stamp;
  logic [31:0]   tok_nxt;
  logic [31:0]   stamp_nxt;
  logic [31:0]   cnt_nxt;

  // Wrap-safe: a stamp is due when it lies at most 2^31-1 cycles in the past.
  function automatic logic is_due(input logic [31:0] cnt, input logic [31:0] stamp);
    logic [31:0] diff;
    diff = cnt - stamp;
    return ~diff[31];
  endfunction

  assign id_match    = (i_id_from_link == 32'(ID));
  assign full        = (level == LVL_FULL);
  assign o_valid     = (state == S_PRESENT);
  assign pop         = o_valid & i_ready;
  assign push        = i_wen_from_link & id_match & (~full | pop);
  assign drop        = i_wen_from_link & id_match & full & ~pop;
  assign rd_ptr_next = rd_ptr + 1'b1;
  assign cnt_nxt     = o_local_cnt + 32'd1;
  assign o_level     = level;

  // The head register reloads from the FIFO when idle or when the current head leaves.
  // A token written in this same cycle is not a candidate; it is picked up one edge later.
  always_comb begin
    if (pop) begin
      cand_avail = (level > LVL_ONE);
      cand_tok   = tok_mem[rd_ptr_next];
      cand_stamp = stamp_mem[rd_ptr_next];
    end else begin
      cand_avail = (level != '0);
      cand_tok   = tok_mem[rd_ptr];
      cand_stamp = stamp_mem[rd_ptr];
    end
  end

  // Due is evaluated against the next counter value so o_valid lines up with o_local_cnt.
  always_comb begin
    state_nxt = state;
    tok_nxt   = o_token;
    stamp_nxt = o_clk_cnt;
    load      = pop | ((state != S_WAIT) & (state != S_PRESENT));
    if (load) begin
      if (cand_avail) begin
        tok_nxt   = cand_tok;
        stamp_nxt = cand_stamp;
        state_nxt = is_due(cnt_nxt, cand_stamp) ? S_PRESENT : S_WAIT;
      end else begin
        tok_nxt   = '0;
        stamp_nxt = '0;
        state_nxt = S_EMPTY;
      end
    end else if ((state == S_WAIT) && is_due(cnt_nxt, o_clk_cnt)) begin
      state_nxt = S_PRESENT;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= S_EMPTY;
      o_token     <= '0;
      o_clk_cnt   <= '0;
      o_local_cnt <= '0;
      o_overflow  <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
    end else begin
      state       <= state_nxt;
      o_token     <= tok_nxt;
      o_clk_cnt   <= stamp_nxt;
      o_local_cnt <= cnt_nxt;
      if (drop) begin
        o_overflow <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_next;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge i_clk) begin
    if (push) begin
      tok_mem[wr_ptr]   <= i_token_from_link;
      stamp_mem[wr_ptr] <= i_clk_cnt_from_link;
    end
  end

endmodule

// File: tb/tb_link_token_rx.sv
// Bench for link_token_rx (ID=3, DEPTH=8): directed steps plus a random phase, every cycle
// compared against a queue-based model of capture, in-order release and timestamps.
module tb_link_token_rx;

  localparam int          DEPTH = 8;
  localparam logic [31:0] MY_ID = 32'd3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wen;
  logic [31:0] token;
  logic [31:0] stamp;
  logic [31:0] id;
  logic        ready;
  logic        o_valid;
  logic [31:0] o_token;
  logic [31:0] o_clk_cnt;
  logic [31:0] o_local_cnt;
  logic [3:0]  o_level;
  logic        o_overflow;

  link_token_rx #(.ID(3), .DEPTH(DEPTH)) dut (
    .i_clk               (clk),
    .i_rstn              (rstn),
    .i_wen_from_link     (wen),
    .i_token_from_link   (token),
    .i_clk_cnt_from_link (stamp),
    .i_id_from_link      (id),
    .o_valid             (o_valid),
    .o_token             (o_token),
    .o_clk_cnt           (o_clk_cnt),
    .i_ready             (ready),
    .o_local_cnt         (o_local_cnt),
    .o_level             (o_level),
    .o_overflow          (o_overflow)
  );

  always #5 clk = ~clk;

  // rdy: first cycle index in which the entry may be presented at the head.
  typedef struct {
    logic [31:0] tok;
    logic [31:0] stamp;
    int          rdy;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mcnt;
  int          ecount;
  logic        movf;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic m_due(input logic [31:0] cnt, input logic [31:0] s);
    return int'(cnt - s) >= 0;
  endfunction

  function automatic logic m_shown();
    return (q.size() > 0) && (ecount >= q[0].rdy);
  endfunction

  function automatic logic m_valid();
    return m_shown() && m_due(mcnt, q[0].stamp);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, "_valid"}, 32'(o_valid), 32'(m_valid()));
    chk({pfx, "_token"}, o_token, m_shown() ? q[0].tok : 32'd0);
    chk({pfx, "_stamp"}, o_clk_cnt, m_shown() ? q[0].stamp : 32'd0);
    chk({pfx, "_level"}, 32'(o_level), 32'(q.size()));
    chk({pfx, "_ovf"}, 32'(o_overflow), 32'(movf));
    chk({pfx, "_cnt"}, o_local_cnt, mcnt);
  endtask

  task automatic cycle(input logic w, input logic [31:0] tk, input logic [31:0] st,
                       input logic [31:0] idv, input logic rd, input string pfx);
    logic pop_m;
    logic match;
    logic full_m;
    wen   = w;
    token = tk;
    stamp = st;
    id    = idv;
    ready = rd;
    pop_m  = m_valid() && rd;
    match  = w && (idv == MY_ID);
    full_m = (q.size() == DEPTH);
    @(posedge clk);
    ecount++;
    mcnt++;
    if (pop_m) q.delete(0);
    if (match && (!full_m || pop_m)) begin
      ent_t e;
      e.tok   = tk;
      e.stamp = st;
      e.rdy   = ecount + 1;
      q.push_back(e);
    end
    if (match && full_m && !pop_m) movf = 1'b1;
    if (pop_m && q.size() > 0 && q[0].rdy < ecount) q[0].rdy = ecount;
    #1;
    check_all(pfx);
  endtask

  task automatic idle(input logic rd, input string pfx);
    cycle(1'b0, 32'd0, 32'd0, 32'd0, rd, pfx);
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    wen   = 1'b0;
    ready = 1'b0;
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_token", o_token, 32'd0);
    chk("rst_stamp", o_clk_cnt, 32'd0);
    chk("rst_level", 32'(o_level), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    chk("rst_cnt", o_local_cnt, 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    q.delete();
    mcnt   = 32'd0;
    ecount = 0;
    movf   = 1'b0;
    check_all("post_rst");
  endtask

  initial begin
    logic        seen;
    int          npop;
    logic [31:0] c;
    rstn  = 1'b1;
    wen   = 1'b0;
    token = '0;
    stamp = '0;
    id    = '0;
    ready = 1'b0;
    #2;
    do_reset();

    // Stamp 10 written at count 2: visible exactly when the counter reads 10.
    idle(1'b1, "t1_idle");
    idle(1'b1, "t1_idle");
    chk("t1_cnt_at_write", o_local_cnt, 32'd2);
    cycle(1'b1, 32'hA5, 32'd10, MY_ID, 1'b1, "t1_wr");
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      idle(1'b1, "t1_wait");
      if (o_valid) seen = 1'b1;
    end
    chk("t1_seen", 32'(seen), 32'd1);
    chk("t1_rise_cnt", o_local_cnt, 32'd10);
    chk("t1_tok", o_token, 32'hA5);
    idle(1'b1, "t1_pop");
    chk("t1_pop_valid", 32'(o_valid), 32'd0);
    chk("t1_pop_level", 32'(o_level), 32'd0);

    // Foreign id is ignored.
    cycle(1'b1, 32'h1234, mcnt, 32'd5, 1'b1, "t2_wr");
    chk("t2_level", 32'(o_level), 32'd0);
    chk("t2_ovf", 32'(o_overflow), 32'd0);

    // Past stamp: o_valid two edges after the write; then full FIFO with pop and push together.
    while (mcnt < 32'd100) idle(1'b1, "t5_run");
    cycle(1'b1, 32'h55, 32'd5, MY_ID, 1'b0, "t5_wr");
    chk("t5_valid_n", 32'(o_valid), 32'd0);
    idle(1'b0, "t5_n1");
    chk("t5_valid_n1", 32'(o_valid), 32'd1);
    chk("t5_tok", o_token, 32'h55);
    for (int i = 0; i < 7; i++) cycle(1'b1, 32'h100 + 32'(i), mcnt, MY_ID, 1'b0, "t5_fill");
    chk("t5_full", 32'(o_level), 32'd8);
    cycle(1'b1, 32'h200, mcnt, MY_ID, 1'b1, "t5_simul");
    chk("t5_simul_level", 32'(o_level), 32'd8);
    chk("t5_simul_ovf", 32'(o_overflow), 32'd0);
    chk("t5_simul_tok", o_token, 32'h100);
    repeat (12) idle(1'b1, "t5_drain");
    chk("t5_drained", 32'(o_level), 32'd0);

    // Nine writes into eight slots with the consumer stalled.
    for (int i = 0; i < 9; i++) cycle(1'b1, 32'h300 + 32'(i), mcnt, MY_ID, 1'b0, "t3_fill");
    chk("t3_level", 32'(o_level), 32'd8);
    chk("t3_ovf", 32'(o_overflow), 32'd1);
    npop = 0;
    for (int i = 0; i < 40 && npop < 8; i++) begin
      if (o_valid) begin
        chk("t3_order", o_token, 32'h300 + 32'(npop));
        npop++;
      end
      idle(1'b1, "t3_drain");
    end
    chk("t3_npop", 32'(npop), 32'd8);
    chk("t3_empty", 32'(o_level), 32'd0);

    // Wrap arithmetic: a huge stamp is just behind a small count, and 2^31-1 back is due.
    cycle(1'b1, 32'h77, 32'hFFFF_FFF0, MY_ID, 1'b0, "w1_wr");
    idle(1'b0, "w1_n1");
    chk("w1_valid", 32'(o_valid), 32'd1);
    idle(1'b1, "w1_pop");
    c = mcnt;
    cycle(1'b1, 32'h78, c + 32'd2 - 32'h7FFF_FFFF, MY_ID, 1'b0, "w2_wr");
    idle(1'b0, "w2_n1");
    chk("w2_valid", 32'(o_valid), 32'd1);
    idle(1'b1, "w2_pop");

    // 2^31 ahead is never due; it blocks three later entries, then reset discards all four.
    c = mcnt;
    cycle(1'b1, 32'h88, c + 32'd2 + 32'h8000_0000, MY_ID, 1'b1, "w3_wr");
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h90 + 32'(i), mcnt, MY_ID, 1'b1, "w3_fill");
    repeat (20) idle(1'b1, "w3_hold");
    chk("w3_blocked", 32'(o_valid), 32'd0);
    chk("w3_level", 32'(o_level), 32'd4);
    chk("w3_stamp", o_clk_cnt, c + 32'd2 + 32'h8000_0000);
    do_reset();
    idle(1'b1, "t6_after");
    chk("t6_cnt", o_local_cnt, 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic        w;
      logic        rd;
      logic [31:0] idv;
      w   = ($urandom_range(0, 2) != 0);
      idv = ($urandom_range(0, 4) == 0) ? 32'd5 : MY_ID;
      rd  = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
      cycle(w, $urandom, mcnt + 32'($urandom_range(0, 40)) - 32'd10, idv, rd, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
